mac_t_loader: RTL

Frame loader sitting directly upstream of the RGMII TX MAC, in the system clock domain. It accepts whole frames from the switch egress buffer, writes payload bytes into the TX data FIFO, and zero-pads runts to the Ethernet minimum. It then posts one 16-bit pointer word per frame into the TX pointer FIFO; the MAC uses bits [11:0] of that word as the frame's byte count. It also rejects malformed lengths and keeps frame and drop statistics.

---
 rtl/mac_pkg.sv | 40 ++++
 rtl/mac_t_loader.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mac_pkg.sv
// mac_pkg: shared TX-side constants, pointer-word layout
// and the one-hot state encoding of the frame loader.
package mac_pkg;

    localparam int MIN_LEN_DEF = 60;
    localparam int MAX_LEN_DEF = 1514;

    localparam int PTR_LEN_MSB = 11;
    localparam int PTR_PAD_BIT = 12;

    localparam int S_IDLE  = 0;
    localparam int S_CHECK = 1;
    localparam int S_READ  = 2;
    localparam int S_DRAIN = 3;
    localparam int S_PAD   = 4;
    localparam int S_PTR   = 5;
    localparam int S_DROP  = 6;

    typedef enum logic [6:0] {
        IDLE  = 7'b000_0001,
        CHECK = 7'b000_0010,
        READ  = 7'b000_0100,
        DRAIN = 7'b000_1000,
        PAD   = 7'b001_0000,
        PTR   = 7'b010_0000,
        DROP  = 7'b100_0000
    } ld_state_t;

    function automatic logic [15:0] ptr_word(
        input logic [11:0] len,
        input logic        pad
    );
        logic [15:0] w;
        w                  = '0;
        w[PTR_LEN_MSB:0]   = len;
        w[PTR_PAD_BIT]     = pad;
        return w;
    endfunction

endpackage

// File: rtl/mac_t_loader.sv
// mac_t_loader: moves whole frames from the egress buffer into
// the TX data/pointer FIFOs, padding runts and dropping bad lengths.
module mac_t_loader
    import mac_pkg::*;
#(
    parameter int DATA_DEPTH = 4096,
    parameter int MIN_LEN    = MIN_LEN_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF
) (
    input  logic        clk,
    input  logic        rstn_sys,
    input  logic        in_req,
    input  logic [11:0] in_len,
    output logic        in_ack,
    output logic        in_rd,
    input  logic [7:0]  in_d,
    output logic        data_fifo_wr,
    output logic [7:0]  data_fifo_din,
    input  logic [12:0] data_fifo_used,
    output logic        ptr_fifo_wr,
    output logic [15:0] ptr_fifo_din,
    input  logic        ptr_fifo_full,
    output logic [15:0] cnt_tx_frame,
    output logic [15:0] cnt_tx_drop
);

    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);
    localparam logic [12:0] DEPTH = 13'(DATA_DEPTH);

    ld_state_t   state_q, state_d;
    logic [11:0] len_q, rem_q, rem_d, plen;
    logic [12:0] free;
    logic        short_len, bad_len, room, pad_q;

    assign short_len = len_q < MIN_L;
    assign plen      = short_len ? MIN_L : len_q;
    assign free      = DEPTH - data_fifo_used;
    assign bad_len   = (len_q == 12'd0) || (len_q > MAX_L);
    assign room      = ({1'b0, plen} <= free) && !ptr_fifo_full;

    // in_d lands the cycle after in_rd, the same cycle as its write strobe
    assign data_fifo_din = (data_fifo_wr && !pad_q) ? in_d : 8'h00;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        unique case (1'b1)
            state_q[S_IDLE]: begin
                if (in_req) state_d = CHECK;
            end
            state_q[S_CHECK]: begin
                if (bad_len) begin
                    state_d = DROP;
                    rem_d   = len_q;
                end else if (room) begin
                    state_d = READ;
                    rem_d   = len_q;
                end
            end
            state_q[S_READ]: begin
                rem_d = rem_q - 12'd1;
                if (rem_q == 12'd1) state_d = DRAIN;
            end
            state_q[S_DRAIN]: begin
                if (short_len) begin
                    state_d = PAD;
                    rem_d   = MIN_L - len_q;
                end else begin
                    state_d = PTR;
                end
            end
            state_q[S_PAD]: begin
                rem_d = rem_q - 12'd1;
                if (rem_q == 12'd1) state_d = PTR;
            end
            state_q[S_PTR]: begin
                state_d = IDLE;
            end
            state_q[S_DROP]: begin
                rem_d = rem_q - 12'd1;
                if (rem_q <= 12'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn_sys) begin
        if (!rstn_sys) begin
            state_q      <= IDLE;
            len_q        <= '0;
            rem_q        <= '0;
            pad_q        <= 1'b0;
            in_ack       <= 1'b0;
            in_rd        <= 1'b0;
            data_fifo_wr <= 1'b0;
            ptr_fifo_wr  <= 1'b0;
            ptr_fifo_din <= '0;
            cnt_tx_frame <= '0;
            cnt_tx_drop  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            if (state_q[S_IDLE] && in_req) len_q <= in_len;
            in_ack <= state_q[S_CHECK] && !state_d[S_CHECK];
            in_rd  <= state_d[S_READ]
                   || (state_d[S_DROP] && len_q != 12'd0);
            data_fifo_wr <= (in_rd && state_q[S_READ])
                         || state_d[S_PAD];
            pad_q        <= state_d[S_PAD];
            ptr_fifo_wr  <= state_d[S_PTR];
            ptr_fifo_din <= state_d[S_PTR]
                          ? ptr_word(plen, short_len) : '0;
            if (state_d[S_PTR])
                cnt_tx_frame <= cnt_tx_frame + 16'd1;
            if (state_q[S_DROP] && state_d[S_IDLE])
                cnt_tx_drop <= cnt_tx_drop + 16'd1;
        end
    end

endmodule
